// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: drives PC enable and per-stage valid/flush from load-use,
// branch, multi-cycle MDU and data-memory wait events; counts stall cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             if_id_valid,
  output logic             if_id_flush,
  output logic             id_ex_valid,
  output logic             id_ex_flush,
  output logic             ex_mem_valid,
  output logic             ex_mem_flush,
  output logic             mem_wb_valid,
  output logic             mem_wb_flush,
  output logic [1:0]       state_o,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMduWait = 2'd1,
    StMemWait = 2'd2,
    StHalt    = 2'd3
  } state_e;

  // Control word: {pc_en, if_id v/f, id_ex v/f, ex_mem v/f, mem_wb v/f}
  localparam logic [8:0] CtrlAdvance  = 9'b1_10_10_10_10;
  localparam logic [8:0] CtrlMemFreeze = 9'b0_00_00_00_01;
  localparam logic [8:0] CtrlMduStall = 9'b0_00_00_01_10;
  localparam logic [8:0] CtrlBranch   = 9'b1_01_01_10_10;
  localparam logic [8:0] CtrlBubble   = 9'b0_00_01_10_10;
  localparam logic [8:0] CtrlKill     = 9'b0_01_01_01_01;

  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [8:0]       ctrl;
  logic             load_use;
  logic [8:0]       run_ctrl;

  assign load_use = ex_mem_read && (ex_rd_addr != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  // RUN rules 2-5, shared by RUN and by the MEM_WAIT completion cycle
  always_comb begin
    if (ex_mdu_start) begin
      run_ctrl = CtrlMduStall;
    end else if (ex_branch_taken) begin
      run_ctrl = CtrlBranch;
    end else if (load_use) begin
      run_ctrl = CtrlBubble;
    end else begin
      run_ctrl = CtrlAdvance;
    end
  end

  always_comb begin
    ctrl    = CtrlAdvance;
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StRun: begin
        timer_d = 8'd0;
        if (mem_req && !mem_ready) begin
          ctrl    = CtrlMemFreeze;
          state_d = StMemWait;
          timer_d = 8'd1;
        end else begin
          ctrl = run_ctrl;
          if (ex_mdu_start) state_d = StMduWait;
        end
      end
      StMduWait: begin
        if (mdu_done) begin
          ctrl    = CtrlAdvance;
          state_d = StRun;
        end else begin
          ctrl = CtrlMduStall;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          ctrl    = run_ctrl;
          timer_d = 8'd0;
          state_d = ex_mdu_start ? StMduWait : StRun;
        end else begin
          ctrl = CtrlMemFreeze;
          if (timer_q >= TimeoutVal) begin
            state_d = StHalt;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      StHalt: begin
        ctrl = CtrlKill;
      end
      default: begin
        ctrl    = CtrlKill;
        state_d = StHalt;
      end
    endcase
    if (reset) ctrl = CtrlKill;
  end

  always_comb begin
    mem_timeout_d = mem_timeout_q || (state_d == StHalt);
    stall_d       = stall_q;
    if (perf_clr) begin
      stall_d = '0;
    end else if (!ctrl[8] && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      timer_q       <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      mem_timeout_q <= mem_timeout_d;
      stall_q       <= stall_d;
    end
  end

  assign {pc_en, if_id_valid, if_id_flush, id_ex_valid, id_ex_flush,
          ex_mem_valid, ex_mem_flush, mem_wb_valid, mem_wb_flush} = ctrl;
  assign state_o      = state_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default and MEM_TIMEOUT=4/CNT_W=4) driven
// in parallel and compared every cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, ex_mdu_start;
  logic       mdu_done, mem_req, mem_ready, perf_clr;

  logic        a_pc, a_ifv, a_iff, a_idv, a_idf, a_exv, a_exf, a_mwv, a_mwf, a_to;
  logic [1:0]  a_st;
  logic [31:0] a_cnt;
  logic        b_pc, b_ifv, b_iff, b_idv, b_idf, b_exv, b_exf, b_mwv, b_mwf, b_to;
  logic [1:0]  b_st;
  logic [3:0]  b_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut_a (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_en(a_pc), .if_id_valid(a_ifv), .if_id_flush(a_iff),
    .id_ex_valid(a_idv), .id_ex_flush(a_idf), .ex_mem_valid(a_exv), .ex_mem_flush(a_exf),
    .mem_wb_valid(a_mwv), .mem_wb_flush(a_mwf),
    .state_o(a_st), .mem_timeout(a_to), .stall_cycles(a_cnt)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .pc_en(b_pc), .if_id_valid(b_ifv), .if_id_flush(b_iff),
    .id_ex_valid(b_idv), .id_ex_flush(b_idf), .ex_mem_valid(b_exv), .ex_mem_flush(b_exf),
    .mem_wb_valid(b_mwv), .mem_wb_flush(b_mwf),
    .state_o(b_st), .mem_timeout(b_to), .stall_cycles(b_cnt)
  );

  // Reference model: states as plain ints (0 RUN, 1 MDU_WAIT, 2 MEM_WAIT, 3 HALT)
  typedef struct {
    int     st;
    int     timer;
    bit     to;
    longint cnt;
  } mst_t;

  mst_t ma, mb;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // pc enable plus per-stage valid and flush, stages ordered IF/ID, ID/EX, EX/MEM, MEM/WB
  function automatic logic [8:0] pack(input bit pc, input bit [3:0] v, input bit [3:0] f);
    return {pc, v[3], f[3], v[2], f[2], v[1], f[1], v[0], f[0]};
  endfunction

  function automatic bit lu_cond();
    return ex_mem_read && (ex_rd_addr != 0) &&
           ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
            (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
  endfunction

  function automatic logic [8:0] rules_2_to_5();
    if (ex_mdu_start)    return pack(0, 4'b0001, 4'b0010);
    if (ex_branch_taken) return pack(1, 4'b0011, 4'b1100);
    if (lu_cond())       return pack(0, 4'b0011, 4'b0100);
    return pack(1, 4'b1111, 4'b0000);
  endfunction

  function automatic logic [8:0] exp_ctrl(input int st);
    logic [8:0] kill   = pack(0, 4'b0000, 4'b1111);
    logic [8:0] freeze = pack(0, 4'b0000, 4'b0001);
    if (reset) return kill;
    case (st)
      0:       return (mem_req && !mem_ready) ? freeze : rules_2_to_5();
      1:       return mdu_done ? pack(1, 4'b1111, 4'b0000) : pack(0, 4'b0001, 4'b0010);
      2:       return mem_ready ? rules_2_to_5() : freeze;
      default: return kill;
    endcase
  endfunction

  function automatic mst_t reset_state();
    mst_t m;
    m.st = 0; m.timer = 0; m.to = 0; m.cnt = 0;
    return m;
  endfunction

  task automatic step(inout mst_t m, input int tmo, input longint cmax);
    logic [8:0] c;
    if (reset) begin
      m = reset_state();
      return;
    end
    c = exp_ctrl(m.st);
    if (perf_clr) m.cnt = 0;
    else if (!c[8] && m.cnt < cmax) m.cnt++;
    case (m.st)
      0: begin
        if (mem_req && !mem_ready) begin m.st = 2; m.timer = 1; end
        else if (ex_mdu_start) m.st = 1;
      end
      1: if (mdu_done) m.st = 0;
      2: begin
        if (mem_ready) begin
          m.timer = 0;
          m.st = ex_mdu_start ? 1 : 0;
        end else if (m.timer == tmo) begin
          m.st = 3; m.to = 1;
        end else begin
          m.timer++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    check("a_ctrl", {a_pc, a_ifv, a_iff, a_idv, a_idf, a_exv, a_exf, a_mwv, a_mwf},
          exp_ctrl(ma.st));
    check("a_state", a_st, ma.st);
    check("a_timeout", a_to, ma.to);
    check("a_stall", a_cnt, ma.cnt);
    check("b_ctrl", {b_pc, b_ifv, b_iff, b_idv, b_idf, b_exv, b_exf, b_mwv, b_mwf},
          exp_ctrl(mb.st));
    check("b_state", b_st, mb.st);
    check("b_timeout", b_to, mb.to);
    check("b_stall", b_cnt, mb.cnt);
  endtask

  // Inputs change at negedge; sample #1 later; model advances at posedge
  task automatic cycle();
    if (ex_branch_taken && ex_mdu_start)
      $display("note: protocol violation, branch and mdu_start both high at %0t", $time);
    #1 check_all();
    @(posedge clk);
    step(ma, 16, 64'hFFFF_FFFF);
    step(mb, 4, 15);
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd_addr = 0; ex_mem_read = 0; ex_branch_taken = 0; ex_mdu_start = 0;
    mdu_done = 0; mem_req = 0; mem_ready = 0; perf_clr = 0;
  endtask

  task automatic assert_reset();
    reset = 1;
    ma = reset_state();
    mb = reset_state();
  endtask

  task automatic pulse_reset();
    assert_reset();
    cycle();
    reset = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1; ex_rd_addr = rd; id_uses_rs1 = 1; id_rs1_addr = rd;
  endtask

  initial begin
    idle();
    assert_reset();
    @(negedge clk);
    cycle();
    reset = 0;
    cycle();

    // Load-use: one bubble, counter 0 -> 1; rd=0 never stalls
    set_lu(5'd5); cycle();
    idle(); cycle();
    check("lu_stall_count", a_cnt, 1);
    set_lu(5'd0); cycle();
    idle(); cycle();
    check("lu_rd0_no_stall", a_cnt, 1);

    // Branch wins over load-use
    set_lu(5'd7); ex_branch_taken = 1; cycle();
    idle(); cycle();
    check("branch_lu_no_stall", a_cnt, 1);

    // MDU: start pulse, five waiting cycles, then done
    perf_clr = 1; cycle(); idle();
    ex_mdu_start = 1; cycle(); ex_mdu_start = 0;
    repeat (5) cycle();
    mdu_done = 1; cycle(); mdu_done = 0;
    check("mdu_stall_count", a_cnt, 6);

    // Protocol violation: mdu_start must take priority over branch
    ex_mdu_start = 1; ex_branch_taken = 1; cycle(); idle();
    mdu_done = 1; cycle(); idle();

    // Memory wait, exit cycle carries a load-use bubble
    mem_req = 1; repeat (3) cycle();
    mem_ready = 1; set_lu(5'd9); cycle();
    idle(); cycle();

    // Timeout on instance b; ready on the 4th wait cycle avoids HALT
    mem_req = 1; cycle(); repeat (3) cycle();
    mem_ready = 1; cycle();
    check("b_no_timeout", b_to, 0);
    mem_ready = 0; cycle(); repeat (4) cycle();
    check("b_halt_timeout", b_to, 1);
    repeat (20) cycle();
    check("b_stall_saturated", b_cnt, 15);
    idle(); cycle();
    pulse_reset();

    // Asynchronous reset in the middle of MDU_WAIT
    ex_mdu_start = 1; cycle(); ex_mdu_start = 0;
    cycle(); cycle();
    #3 assert_reset();
    #1 check_all();
    check("rst_async_pc_en", a_pc, 0);
    @(negedge clk);
    cycle();
    reset = 0;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      id_rs1_addr     = 5'($urandom_range(0, 3));
      id_rs2_addr     = 5'($urandom_range(0, 3));
      ex_rd_addr      = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 99) < 40);
      ex_mdu_start    = ($urandom_range(0, 99) < 10);
      ex_branch_taken = !ex_mdu_start && ($urandom_range(0, 99) < 15);
      mdu_done        = ($urandom_range(0, 99) < 30);
      mem_req         = ($urandom_range(0, 99) < 40);
      mem_ready       = ($urandom_range(0, 99) < 65);
      perf_clr        = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 199) == 0) begin
        #2 assert_reset();
        cycle();
        reset = 0;
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
